// File: rtl/stack_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : stack_cmd_master_if
//  Brief    : Host request/response channel of the stack command master.
//  Revision : 1.0  initial release
// ============================================================================
interface stack_cmd_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/stack_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : stack_cmd_master
//  Brief    : Host-to-pin initiator for the 8-bit stack peripheral with a
//             shadow occupancy count and flag-consistency monitor.
//  Revision : 1.0  initial release
// ============================================================================
module stack_cmd_master #(
    parameter int DEPTH   = 16,
    parameter int RSP_LAT = 1,
    parameter int LW      = $clog2(DEPTH + 1)
) (
    input  wire                 clk,
    input  wire                 rst,
    stack_cmd_master_if.slave   bus,
    output logic [1:0]          stk_cmd_o,
    output logic [7:0]          stk_data_o,
    input  wire  [7:0]          stk_data_i,
    input  wire                 stk_full_i,
    input  wire                 stk_empty_i,
    output logic [LW-1:0]       level,
    output logic                desync
);

    localparam logic [1:0]    c_op_nop  = 2'b00;
    localparam logic [1:0]    c_op_push = 2'b01;
    localparam logic [1:0]    c_op_pop  = 2'b10;
    localparam logic [1:0]    c_op_peek = 2'b11;
    localparam logic [LW-1:0] c_depth   = LW'(DEPTH);
    localparam logic [3:0]    c_lat     = 4'(RSP_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [7:0]    r_data;
    logic [3:0]    r_cnt;
    logic          w_illegal;
    logic [LW-1:0] w_level_next;

    always_comb begin
        w_illegal = 1'b0;
        case (r_op)
            c_op_push: w_illegal = (level == c_depth) || stk_full_i;
            c_op_pop,
            c_op_peek: w_illegal = (level == '0) || stk_empty_i;
            default:   w_illegal = 1'b0;
        endcase
    end

    always_comb begin
        w_level_next = level;
        if (r_op == c_op_push && level != c_depth)
            w_level_next = level + LW'(1);
        else if (r_op == c_op_pop && level != '0)
            w_level_next = level - LW'(1);
    end

    // The legality check sees the live stack flags, so the pins follow it
    // combinationally within the single issue cycle.
    assign stk_cmd_o  = (r_state == S_ISSUE && !w_illegal) ? r_op   : c_op_nop;
    assign stk_data_o = (r_state == S_ISSUE && !w_illegal) ? r_data : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= c_op_nop;
            r_data        <= 8'h00;
            r_cnt         <= 4'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'h00;
            bus.rsp_err   <= 1'b0;
            level         <= '0;
            desync        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op          <= bus.req_op;
                        r_data        <= bus.req_data;
                        bus.req_ready <= 1'b0;
                        bus.rsp_data  <= 8'h00;
                        bus.rsp_err   <= 1'b0;
                        r_state       <= (bus.req_op == c_op_nop) ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_illegal) begin
                        bus.rsp_err <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt   <= c_lat;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        bus.rsp_data  <= (r_op == c_op_pop || r_op == c_op_peek) ? stk_data_i : 8'h00;
                        level         <= w_level_next;
                        if (((w_level_next == '0) != stk_empty_i) ||
                            ((w_level_next == c_depth) != stk_full_i))
                            desync <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    // NOP and rejected ops arrive with rsp_valid low; it rises
                    // one cycle after entry, giving them their fixed latency.
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_cmd_master
//  Brief    : Self-checking bench: pin-level stack model plus a transaction
//             level reference queue for the stack command master.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stack_cmd_master;
    localparam int DEPTH   = 16;
    localparam int RSP_LAT = 1;
    localparam int LW      = $clog2(DEPTH + 1);
    localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, PEEK = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    stk_cmd_o;
    logic [7:0]    stk_data_o;
    logic [7:0]    stk_data_i;
    logic          stk_full_i;
    logic          stk_empty_i;
    logic [LW-1:0] level;
    logic          desync;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] ref_q[$];

    stack_cmd_master_if bus ();

    stack_cmd_master #(.DEPTH(DEPTH), .RSP_LAT(RSP_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stk_cmd_o(stk_cmd_o), .stk_data_o(stk_data_o), .stk_data_i(stk_data_i),
        .stk_full_i(stk_full_i), .stk_empty_i(stk_empty_i),
        .level(level), .desync(desync)
    );

    always #5 clk = ~clk;

    // Pin-level stack peripheral: registered data out, flags from occupancy.
    logic [7:0] mem [DEPTH];
    int         msp;
    logic [7:0] mdata;
    logic       frc_empty = 1'b0;
    logic       frc_full  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            msp   <= 0;
            mdata <= 8'h00;
        end else begin
            case (stk_cmd_o)
                PUSH: if (msp < DEPTH) begin mem[msp] <= stk_data_o; msp <= msp + 1; end
                POP:  if (msp > 0) begin mdata <= mem[msp-1]; msp <= msp - 1; end
                PEEK: if (msp > 0) mdata <= mem[msp-1];
                default: ;
            endcase
        end
    end

    assign stk_data_i  = mdata;
    assign stk_empty_i = (msp == 0) || frc_empty;
    assign stk_full_i  = (msp == DEPTH) || frc_full;

    // Transaction-level reference: expected outcome of one host request.
    task automatic ref_apply(input logic [1:0] op, input logic [7:0] d, input bit fe, input bit ff,
                             output bit e_err, output logic [7:0] e_data, output int e_lat, output int e_pins);
        e_err = 1'b0; e_data = 8'h00; e_lat = 1 + RSP_LAT; e_pins = 1;
        case (op)
            NOP:  begin e_lat = 1; e_pins = 0; end
            PUSH: if (ref_q.size() >= DEPTH || ff) e_err = 1'b1; else ref_q.push_back(d);
            POP:  if (ref_q.size() == 0 || fe) e_err = 1'b1; else e_data = ref_q.pop_back();
            default: if (ref_q.size() == 0 || fe) e_err = 1'b1; else e_data = ref_q[$];
        endcase
        if (e_err) begin e_lat = 2; e_pins = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk); #1 rst = 1'b0;
        ref_q.delete();
    endtask

    // Drives one request and observes the pins until rsp_valid is seen.
    task automatic run_op(input logic [1:0] op, input logic [7:0] d,
                          output logic [7:0] o_data, output logic o_err, output int lat,
                          output int npin, output int pcyc, output logic [1:0] pcmd, output logic [7:0] pdata);
        int  cyc;
        bit  done;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_op = NOP; bus.req_data = 8'h00;
        cyc = 0; done = 1'b0; npin = 0; pcyc = -1; pcmd = NOP; pdata = 8'h00; lat = -1;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (stk_cmd_o != NOP || stk_data_o != 8'h00) begin
                npin++; pcmd = stk_cmd_o; pdata = stk_data_o;
                if (pcyc < 0) pcyc = cyc;
            end
            if (bus.rsp_valid) begin done = 1'b1; lat = cyc; end
            else begin @(posedge clk); cyc++; end
        end
        o_data = bus.rsp_data;
        o_err  = bus.rsp_err;
    endtask

    task automatic complete_rsp(input int hold);
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
    endtask

    logic [7:0] o_data, pdata, e_data;
    logic       o_err;
    logic [1:0] pcmd;
    bit         e_err;
    int         lat, npin, pcyc, e_lat, e_pins;

    task automatic test_reset();
        @(negedge clk); #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, stk_cmd_o, stk_data_o, level, desync}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, {LW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h err=%b cmd=%b sdat=%h lvl=%0d dsy=%b want 1 0 00 0 00 00 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, stk_cmd_o, stk_data_o, level, desync);
        end
        @(posedge clk); #1 rst = 1'b0;
        ref_q.delete();
    endtask

    task automatic test_first_push();
        do_reset();
        ref_apply(PUSH, 8'hA5, 0, 0, e_err, e_data, e_lat, e_pins);
        run_op(PUSH, 8'hA5, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        vectors++; if (pcmd !== PUSH || pdata !== 8'hA5 || npin != 1 || pcyc != 0) begin errors++;
            $display("FAIL first_push_pins: cmd=%b data=%h cycles=%0d at=%0d want 01 a5 1 0", pcmd, pdata, npin, pcyc); end
        vectors++; if (lat != 2) begin errors++; $display("FAIL first_push_latency: got %0d want 2", lat); end
        vectors++; if (o_err !== 1'b0) begin errors++; $display("FAIL first_push_err: got %b want 0", o_err); end
        complete_rsp(0);
        vectors++; if (level !== LW'(1)) begin errors++; $display("FAIL first_push_level: got %0d want 1", level); end
    endtask

    task automatic test_lifo();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] want [3] = '{8'h33, 8'h22, 8'h11};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ref_apply(PUSH, vals[i], 0, 0, e_err, e_data, e_lat, e_pins);
            run_op(PUSH, vals[i], o_data, o_err, lat, npin, pcyc, pcmd, pdata);
            complete_rsp(0);
        end
        vectors++; if (level !== LW'(3)) begin errors++; $display("FAIL lifo_level3: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            ref_apply(POP, 8'h00, 0, 0, e_err, e_data, e_lat, e_pins);
            run_op(POP, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
            vectors++; if (o_data !== want[i] || o_data !== e_data || o_err !== 1'b0) begin errors++;
                $display("FAIL lifo_pop%0d: got data=%h err=%b want %h 0", i, o_data, o_err, want[i]); end
            complete_rsp(0);
            vectors++; if (level !== LW'(2 - i)) begin errors++; $display("FAIL lifo_level: got %0d want %0d", level, 2 - i); end
        end
        vectors++; if (desync !== 1'b0) begin errors++; $display("FAIL lifo_desync: got %b want 0", desync); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        run_op(POP, 8'h3C, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        vectors++; if (o_err !== 1'b1 || o_data !== 8'h00) begin errors++;
            $display("FAIL pop_empty_err: got err=%b data=%h want 1 00", o_err, o_data); end
        vectors++; if (npin != 0 || lat != 2) begin errors++;
            $display("FAIL pop_empty_pins_lat: got pins=%0d lat=%0d want 0 2", npin, lat); end
        complete_rsp(0);
        vectors++; if (level !== LW'(0) || bus.rsp_err !== 1'b0) begin errors++;
            $display("FAIL pop_empty_after: got level=%0d err=%b want 0 0", level, bus.rsp_err); end
    endtask

    task automatic test_full();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom_range(0, 255));
            ref_apply(PUSH, d, 0, 0, e_err, e_data, e_lat, e_pins);
            run_op(PUSH, d, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
            complete_rsp(0);
        end
        vectors++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_level: got %0d want %0d", level, DEPTH); end
        run_op(PUSH, 8'h77, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        vectors++; if (o_err !== 1'b1 || npin != 0 || lat != 2) begin errors++;
            $display("FAIL push_full: got err=%b pins=%0d lat=%0d want 1 0 2", o_err, npin, lat); end
        complete_rsp(0);
        vectors++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL push_full_level: got %0d want %0d", level, DEPTH); end
        ref_apply(PEEK, 8'h00, 0, 0, e_err, e_data, e_lat, e_pins);
        run_op(PEEK, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        vectors++; if (o_data !== e_data || o_err !== 1'b0 || pcmd !== PEEK) begin errors++;
            $display("FAIL peek_full: got data=%h err=%b cmd=%b want %h 0 11", o_data, o_err, pcmd, e_data); end
        complete_rsp(0);
        vectors++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL peek_full_level: got %0d want %0d", level, DEPTH); end
    endtask

    task automatic test_hold();
        logic [7:0] held;
        ref_apply(POP, 8'h00, 0, 0, e_err, e_data, e_lat, e_pins);
        run_op(POP, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        held = o_data;
        vectors++; if (held !== e_data) begin errors++; $display("FAIL hold_pop_data: got %h want %h", held, e_data); end
        bus.req_valid = 1'b1; bus.req_op = NOP;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0) begin errors++;
                $display("FAIL hold_stable%0d: got vld=%b data=%h rdy=%b want 1 %h 0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, held); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL hold_after_hs: got vld=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL hold_accept: got rdy=%b want 0", bus.req_ready); end
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin errors++;
            $display("FAIL hold_nop_rsp: got vld=%b data=%h err=%b want 1 00 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        complete_rsp(0);
    endtask

    task automatic test_desync();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ref_apply(PUSH, 8'(8'h40 + i), 0, 0, e_err, e_data, e_lat, e_pins);
            run_op(PUSH, 8'(8'h40 + i), o_data, o_err, lat, npin, pcyc, pcmd, pdata);
            complete_rsp(0);
        end
        frc_empty = 1'b1;
        ref_apply(POP, 8'h00, 1, 0, e_err, e_data, e_lat, e_pins);
        run_op(POP, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        vectors++; if (o_err !== 1'b1 || npin != 0) begin errors++;
            $display("FAIL forced_empty_reject: got err=%b pins=%0d want 1 0", o_err, npin); end
        complete_rsp(0);
        frc_empty = 1'b0;
        frc_full  = 1'b1;
        ref_apply(PEEK, 8'h00, 0, 1, e_err, e_data, e_lat, e_pins);
        run_op(PEEK, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        complete_rsp(0);
        frc_full = 1'b0;
        vectors++; if (desync !== 1'b1 || o_data !== e_data) begin errors++;
            $display("FAIL desync_set: got desync=%b data=%h want 1 %h", desync, o_data, e_data); end
        ref_apply(PEEK, 8'h00, 0, 0, e_err, e_data, e_lat, e_pins);
        run_op(PEEK, 8'h00, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
        complete_rsp(0);
        vectors++; if (desync !== 1'b1 || level !== LW'(2)) begin errors++;
            $display("FAIL desync_sticky: got desync=%b level=%0d want 1 2", desync, level); end
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = PUSH; bus.req_data = 8'h5A;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, stk_cmd_o, stk_data_o, level, desync}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 8'h00, {LW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_wait: got rdy=%b vld=%b data=%h err=%b cmd=%b sdat=%h lvl=%0d dsy=%b want 1 0 00 0 00 00 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, stk_cmd_o, stk_data_o, level, desync);
        end
        @(posedge clk); #1 rst = 1'b0;
        ref_q.delete();
        repeat (3) @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0 || level !== LW'(0) || stk_cmd_o !== NOP) begin errors++;
            $display("FAIL no_replay: got vld=%b level=%0d cmd=%b want 0 0 00", bus.rsp_valid, level, stk_cmd_o); end
    endtask

    task automatic test_random();
        int         r;
        logic [1:0] op;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? NOP : (r <= 5) ? PUSH : (r <= 7) ? POP : PEEK;
            d  = 8'($urandom_range(0, 255));
            ref_apply(op, d, 0, 0, e_err, e_data, e_lat, e_pins);
            run_op(op, d, o_data, o_err, lat, npin, pcyc, pcmd, pdata);
            vectors++; if (o_err !== e_err || o_data !== e_data) begin errors++;
                $display("FAIL rand%0d_rsp op=%b: got err=%b data=%h want %b %h", i, op, o_err, o_data, e_err, e_data); end
            vectors++; if (lat != e_lat || npin != e_pins) begin errors++;
                $display("FAIL rand%0d_timing op=%b: got lat=%0d pins=%0d want %0d %0d", i, op, lat, npin, e_lat, e_pins); end
            if (e_pins == 1) begin
                vectors++; if (pcmd !== op || pdata !== d) begin errors++;
                    $display("FAIL rand%0d_pins: got cmd=%b data=%h want %b %h", i, pcmd, pdata, op, d); end
            end
            complete_rsp(int'($urandom_range(0, 2)));
            vectors++; if (level !== LW'(ref_q.size()) || desync !== 1'b0) begin errors++;
                $display("FAIL rand%0d_level: got level=%0d desync=%b want %0d 0", i, level, desync, ref_q.size()); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = NOP; bus.req_data = 8'h00; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_first_push();
        test_lifo();
        test_pop_empty();
        test_full();
        test_hold();
        test_desync();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", errors);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/stack_cmd_master.md
Name: stack_cmd_master

Overview:
- Bus-side initiator for the 8-bit stack peripheral's pin interface.
- Takes push/pop/peek requests from a host over a valid/ready channel, drives the stack's command and data pins for one cycle, waits a fixed response latency, then samples the stack's data and flag outputs.
- Returns each result on a valid/ready response channel.
- Keeps a shadow occupancy count, rejects illegal operations before they reach the pins, and flags any disagreement between the shadow count and the stack's own flags.

Parameters:
- DEPTH, 16: stack capacity in entries. Sizes the shadow count. Legal range 2..255.
- RSP_LAT, 1: number of cycles after the issue cycle before the stack outputs are valid. Legal range 1..15.
- LW, $clog2(DEPTH+1): width of the level output. Derived; not overridden.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 PEEK.
- req_data  in  8  push operand; ignored for other operations.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  8  value sampled from the stack for POP/PEEK; 0 for NOP/PUSH/error.
- rsp_err  out  1  operation rejected; no command reached the pins.
- stk_cmd_o  out  2  to stack uio_in[1:0]; same encoding as req_op.
- stk_data_o  out  8  to stack ui_in.
- stk_data_i  in  8  from stack uo_out.
- stk_full_i  in  1  from stack uio_out[1].
- stk_empty_i  in  1  from stack uio_out[0].
- level  out  LW  shadow occupancy count.
- desync  out  1  sticky mismatch between the shadow count and the stack flags.

Behaviour:
- Reset, asynchronous, effective immediately on assertion:
  - state goes to IDLE;
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0;
  - stk_cmd_o=00, stk_data_o=0;
  - level=0, desync=0;
  - any in-flight operation is aborted and not replayed.
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) at edge T latches op and data.
  - NOP goes directly to RESP.
  - Any other op goes to ISSUE.
- ISSUE: the legality check runs in this cycle. It is illegal when:
  - PUSH with level==DEPTH or stk_full_i=1;
  - POP or PEEK with level==0 or stk_empty_i=1.
- Illegal operation in ISSUE: stk_cmd_o stays 00, rsp_err is latched to 1, next state is RESP.
- Legal operation in ISSUE:
  - stk_cmd_o=op and stk_data_o=latched data for exactly this one cycle; both are 0 in every other cycle.
  - The latency counter loads RSP_LAT.
  - Next state is WAIT.
- WAIT:
  - stk_cmd_o=00. The counter decrements each cycle.
  - On the edge where the counter reaches 0:
    - POP/PEEK: stk_data_i is captured into rsp_data. PUSH: rsp_data=0.
    - level updates: PUSH +1, POP -1, PEEK unchanged.
    - The desync check runs against the post-update level. desync is set if (level==0) != stk_empty_i, or if (level==DEPTH) != stk_full_i.
    - Next state is RESP.
- Latency, from acceptance at edge T:
  - legal op: issue cycle is T+1, sample edge is T+1+RSP_LAT, rsp_valid rises at T+1+RSP_LAT;
  - rejected op: rsp_valid rises at T+2;
  - NOP: rsp_valid rises at T+1.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, rsp_err=0, next state is IDLE.
  - Back-to-back requests: the next request can be accepted no earlier than the cycle after the response handshake.
- level:
  - only changes in WAIT completion;
  - never wraps (the pre-check guarantees it);
  - saturates at 0 and DEPTH defensively.
- desync is sticky and is cleared only by rst.
- req_valid and req_op are ignored outside IDLE; there is no queuing.

Test Plan:
- Reset, then PUSH 0xA5 -> issue cycle T+1 shows stk_cmd_o=01 and stk_data_o=0xA5; rsp_valid at T+2 with RSP_LAT=1; rsp_err=0; level=1.
- PUSH 0x11, 0x22, 0x33, then POP x3 against the stack model -> rsp_data returns 0x33, 0x22, 0x11; level goes 3 to 0; desync stays 0.
- POP on an empty stack -> rsp_err=1; stk_cmd_o stays 00 throughout; rsp_valid at T+2; level remains 0.
- Fill to 16, then PUSH 0x77 -> rsp_err=1, no pin activity, level stays 16. Then PEEK -> returns the top value, level stays 16.
- Hold rsp_ready=0 for 5 cycles after a POP -> rsp_valid and rsp_data are stable for all 5; req_ready=0 throughout; the request is accepted only after the handshake.
- Model forces stk_empty_i=1 while level=2 before a POP -> the legal check rejects with rsp_err=1. Separately, force a flag mismatch at a sample edge -> desync=1 and stays set until rst is pulsed mid-WAIT; after that, all outputs are at reset values and level=0.
